pp_hop_wr: RTL and testbench

PP_HOP_WR -- requirements
Module: pp_hop_wr

---
 rtl/pp_hop_wr_pkg.sv | 20 ++
 rtl/pp_hop_wr.sv | 141 ++++++++++++++
 tb/tb_pp_hop_wr.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_hop_wr_pkg.sv
// Shared types for the ping-pong hop writer: FSM states, buffer status encoding
// and the hop/meta field widths used across the packet-parser slice.
package pp_hop_wr_pkg;

  localparam int HOP_INFO_NBITS    = 16;
  localparam int PP_META_RCI_NBITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DROP  = 2'd3
  } wr_state_e;

  typedef enum logic {
    BUF_FREE = 1'b0,
    BUF_BUSY = 1'b1
  } buf_status_e;

endpackage

// File: rtl/pp_hop_wr.sv
// Writes one packet's hop records into one of two ping-pong hop FIFOs and
// emits the packet RCI once per packet; buffers are released by parse_done.
module pp_hop_wr
  import pp_hop_wr_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hop_in_valid,
  input  logic                         hop_in_sop,
  input  logic                         hop_in_eop,
  input  logic [HOP_INFO_NBITS-1:0]    hop_in_data,
  input  logic [PP_META_RCI_NBITS-1:0] hop_in_rci,
  output logic                         hop_in_ready,
  output logic                         hop_fifo_reset0,
  output logic                         hop_fifo_reset1,
  output logic                         hop_fifo_wr0,
  output logic                         hop_fifo_wr1,
  output logic [HOP_INFO_NBITS-1:0]    hop_fifo_wdata0,
  output logic [HOP_INFO_NBITS-1:0]    hop_fifo_wdata1,
  input  logic                         hop_fifo_full0,
  input  logic                         hop_fifo_full1,
  input  logic                         parse_done0,
  input  logic                         parse_done1,
  output logic                         pp_meta_valid,
  output logic [PP_META_RCI_NBITS-1:0] pp_meta_rci,
  output logic                         proto_err
);

  wr_state_e   state_reg, state_next;
  logic        wptr_reg, wptr_next;
  logic        first_reg, first_next;
  buf_status_e buf_reg [2];

  logic [1:0] fifo_full;
  logic [1:0] parse_done;
  logic [1:0] clr_sel;
  logic       cur_busy;
  logic       ready;
  logic       clr_any;
  logic       wr_any;
  logic       meta;
  logic       perr;

  assign fifo_full  = {hop_fifo_full1, hop_fifo_full0};
  assign parse_done = {parse_done1, parse_done0};
  assign clr_sel    = {clr_any & wptr_reg, clr_any & ~wptr_reg};
  assign cur_busy   = (buf_reg[wptr_reg] == BUF_BUSY);

  // A buffer is claimed by its CLR cycle and released by the parser; the
  // claim can never coincide with a legitimate release of the same buffer.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (rst)
          buf_reg[gi] <= BUF_FREE;
        else if (clr_sel[gi])
          buf_reg[gi] <= BUF_BUSY;
        else if (parse_done[gi])
          buf_reg[gi] <= BUF_FREE;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      wptr_reg  <= 1'b0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      first_reg <= first_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    first_next = first_reg;
    ready      = 1'b0;
    clr_any    = 1'b0;
    wr_any     = 1'b0;
    meta       = 1'b0;
    perr       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (hop_in_valid && !hop_in_sop) begin
          ready = 1'b1;
          perr  = 1'b1;
        end else if (hop_in_valid && !cur_busy) begin
          state_next = ST_CLR;
        end
      end
      ST_CLR: begin
        clr_any    = 1'b1;
        first_next = 1'b1;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (hop_in_valid && hop_in_sop && !first_reg) begin
          ready = 1'b1;
          perr  = 1'b1;
        end else begin
          ready = ~fifo_full[wptr_reg];
          if (hop_in_valid && ready) begin
            wr_any     = 1'b1;
            first_next = 1'b0;
            meta       = first_reg & hop_in_sop;
            if (hop_in_eop) begin
              wptr_next  = ~wptr_reg;
              state_next = ST_IDLE;
            end
          end
        end
        // An early release still lets this cycle's beat land, then drains the rest.
        if (parse_done[wptr_reg] && state_next == ST_WRITE)
          state_next = ST_DROP;
      end
      ST_DROP: begin
        ready = 1'b1;
        if (hop_in_valid && hop_in_eop) begin
          wptr_next  = ~wptr_reg;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign hop_in_ready    = ready;
  assign hop_fifo_reset0 = clr_sel[0];
  assign hop_fifo_reset1 = clr_sel[1];
  assign hop_fifo_wr0    = wr_any & ~wptr_reg;
  assign hop_fifo_wr1    = wr_any & wptr_reg;
  assign hop_fifo_wdata0 = wr_any ? hop_in_data : '0;
  assign hop_fifo_wdata1 = wr_any ? hop_in_data : '0;
  assign pp_meta_valid   = meta;
  assign pp_meta_rci     = meta ? hop_in_rci : '0;
  assign proto_err       = perr;

endmodule

// File: tb/tb_pp_hop_wr.sv
// Bench for pp_hop_wr: cycle vector table, a back-pressure sequence and a
// randomized packet stream checked against a packet-level scoreboard.
module tb_pp_hop_wr;
  import pp_hop_wr_pkg::*;

  localparam int DW = HOP_INFO_NBITS;
  localparam int RW = PP_META_RCI_NBITS;
  localparam logic [6:0] R = 7'd64, S0 = 7'd32, S1 = 7'd16, W0 = 7'd8, W1 = 7'd4, M = 7'd2, E = 7'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic          hop_in_valid, hop_in_sop, hop_in_eop;
  logic [DW-1:0] hop_in_data;
  logic [RW-1:0] hop_in_rci;
  logic          hop_in_ready;
  logic          hop_fifo_reset0, hop_fifo_reset1, hop_fifo_wr0, hop_fifo_wr1;
  logic [DW-1:0] hop_fifo_wdata0, hop_fifo_wdata1;
  logic          hop_fifo_full0, hop_fifo_full1, parse_done0, parse_done1;
  logic          pp_meta_valid;
  logic [RW-1:0] pp_meta_rci;
  logic          proto_err;

  pp_hop_wr dut (
    .clk(clk), .rst(rst),
    .hop_in_valid(hop_in_valid), .hop_in_sop(hop_in_sop), .hop_in_eop(hop_in_eop),
    .hop_in_data(hop_in_data), .hop_in_rci(hop_in_rci), .hop_in_ready(hop_in_ready),
    .hop_fifo_reset0(hop_fifo_reset0), .hop_fifo_reset1(hop_fifo_reset1),
    .hop_fifo_wr0(hop_fifo_wr0), .hop_fifo_wr1(hop_fifo_wr1),
    .hop_fifo_wdata0(hop_fifo_wdata0), .hop_fifo_wdata1(hop_fifo_wdata1),
    .hop_fifo_full0(hop_fifo_full0), .hop_fifo_full1(hop_fifo_full1),
    .parse_done0(parse_done0), .parse_done1(parse_done1),
    .pp_meta_valid(pp_meta_valid), .pp_meta_rci(pp_meta_rci), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Downstream FIFO and meta-sink models, fed from the DUT's write strobes.
  logic [DW-1:0] fq0[$];
  logic [DW-1:0] fq1[$];
  logic [RW-1:0] meta_q[$];
  int            perr_cnt = 0;

  always @(negedge clk) begin
    if (hop_fifo_reset0) fq0.delete();
    if (hop_fifo_reset1) fq1.delete();
    if (hop_fifo_wr0) begin
      fq0.push_back(hop_fifo_wdata0);
      check("wr0_while_full", {63'd0, hop_fifo_full0}, 64'd0);
    end
    if (hop_fifo_wr1) begin
      fq1.push_back(hop_fifo_wdata1);
      check("wr1_while_full", {63'd0, hop_fifo_full1}, 64'd0);
    end
    if (pp_meta_valid) meta_q.push_back(pp_meta_rci);
    if (proto_err) perr_cnt++;
  end

  // Parser stand-in: releases a buffer some cycles after its packet completes.
  logic rand_phase = 1'b0;
  int   rel_cnt [2];

  initial begin
    rel_cnt[0] = 0;
    rel_cnt[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_phase) begin
        parse_done0 = 1'b0;
        parse_done1 = 1'b0;
        if (rel_cnt[0] > 0) begin rel_cnt[0]--; if (rel_cnt[0] == 0) parse_done0 = 1'b1; end
        if (rel_cnt[1] > 0) begin rel_cnt[1]--; if (rel_cnt[1] == 0) parse_done1 = 1'b1; end
      end
    end
  end

  typedef struct {
    logic rst, valid, sop, eop;
    logic [DW-1:0] data;
    logic [RW-1:0] rci;
    logic f0, pd0, pd1;
    logic [6:0] flags;
    logic [RW-1:0] erci;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, v, s, e, input logic [DW-1:0] d, input logic [RW-1:0] c,
                     input logic f0, p0, p1, input logic [6:0] fl, input logic [RW-1:0] ec);
    vec_t t;
    t.rst = r; t.valid = v; t.sop = s; t.eop = e; t.data = d; t.rci = c;
    t.f0 = f0; t.pd0 = p0; t.pd1 = p1; t.flags = fl; t.erci = ec;
    vecs.push_back(t);
  endtask

  task automatic idle_inputs();
    hop_in_valid = 0; hop_in_sop = 0; hop_in_eop = 0; hop_in_data = '0; hop_in_rci = '0;
    hop_fifo_full0 = 0; hop_fifo_full1 = 0; parse_done0 = 0; parse_done1 = 0;
  endtask

  task automatic do_reset();
    rand_phase = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fq0.delete(); fq1.delete(); meta_q.delete(); perr_cnt = 0;
  endtask

  function automatic bit q_equal(input logic [DW-1:0] a[$], input logic [DW-1:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] hops[$];
    logic [DW-1:0] got_q[$];
    logic [RW-1:0] prci;
    int idx, low, full_left, cyc, n, b, waitc;
    bit started, full_done, aborted, accepted;

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);

    //   rst v sop eop data    rci f0 pd0 pd1 expected            rci
    add(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 7'd0,            0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 7'd0,            0);
    add(0, 1, 0, 0, 16'h00AA, 0, 0, 0, 0, R | E,           0);
    add(0, 1, 1, 0, 16'h0011, 5, 0, 0, 0, 7'd0,            0);
    add(0, 1, 1, 0, 16'h0011, 5, 0, 0, 0, S0,              0);
    add(0, 1, 1, 0, 16'h0011, 5, 0, 0, 0, R | W0 | M,      5);
    add(0, 1, 1, 0, 16'h0099, 6, 0, 0, 0, R | E,           0);
    add(0, 1, 0, 0, 16'h0022, 0, 0, 0, 0, R | W0,          0);
    add(0, 1, 0, 1, 16'h0033, 0, 0, 0, 0, R | W0,          0);
    add(0, 1, 1, 1, 16'h0044, 7, 0, 0, 0, 7'd0,            0);
    add(0, 1, 1, 1, 16'h0044, 7, 0, 0, 0, S1,              0);
    add(0, 1, 1, 1, 16'h0044, 7, 0, 0, 0, R | W1 | M,      7);
    add(0, 1, 1, 0, 16'h0055, 9, 0, 0, 0, 7'd0,            0);
    add(0, 1, 1, 0, 16'h0055, 9, 0, 1, 0, 7'd0,            0);
    add(0, 1, 1, 0, 16'h0055, 9, 0, 0, 0, 7'd0,            0);
    add(0, 1, 1, 0, 16'h0055, 9, 0, 0, 0, S0,              0);
    add(0, 1, 1, 0, 16'h0055, 9, 1, 0, 0, 7'd0,            0);
    add(0, 1, 1, 0, 16'h0055, 9, 0, 0, 0, R | W0 | M,      9);
    add(0, 1, 0, 0, 16'h0066, 0, 0, 1, 0, R | W0,          0);
    add(0, 1, 0, 0, 16'h0077, 0, 0, 0, 0, R,               0);
    add(0, 1, 0, 1, 16'h0088, 0, 0, 0, 0, R,               0);
    add(0, 1, 1, 0, 16'h0012, 3, 0, 0, 1, 7'd0,            0);
    add(0, 1, 1, 0, 16'h0012, 3, 0, 0, 0, 7'd0,            0);
    add(0, 1, 1, 0, 16'h0012, 3, 0, 0, 0, S1,              0);
    add(0, 1, 1, 0, 16'h0012, 3, 0, 0, 0, R | W1 | M,      3);
    add(1, 1, 0, 0, 16'h0034, 0, 0, 0, 0, R | W1,          0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 7'd0,            0);
    add(0, 1, 1, 0, 16'h0056, 4, 0, 0, 0, 7'd0,            0);
    add(0, 1, 1, 0, 16'h0056, 4, 0, 0, 0, S0,              0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, R,               0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; hop_in_valid = vecs[i].valid; hop_in_sop = vecs[i].sop;
      hop_in_eop = vecs[i].eop; hop_in_data = vecs[i].data; hop_in_rci = vecs[i].rci;
      hop_fifo_full0 = vecs[i].f0; hop_fifo_full1 = 1'b0;
      parse_done0 = vecs[i].pd0; parse_done1 = vecs[i].pd1;
      @(negedge clk);
      exp_wd = ((vecs[i].flags & (W0 | W1)) != 0) ? vecs[i].data : '0;
      check($sformatf("vec%0d", i),
            {17'd0, hop_in_ready, hop_fifo_reset0, hop_fifo_reset1, hop_fifo_wr0, hop_fifo_wr1,
             pp_meta_valid, proto_err, pp_meta_rci, hop_fifo_wdata0, hop_fifo_wdata1},
            {17'd0, vecs[i].flags, vecs[i].erci, exp_wd, exp_wd});
      $display("vec %0d applied", i);
    end

    // Six-hop packet with FIFO0 reporting full for four cycles after hop 2.
    do_reset();
    hops.delete();
    for (int i = 0; i < 6; i++) hops.push_back(DW'(16'hC000 + i));
    idx = 0; low = 0; full_left = 0; cyc = 0; started = 0; full_done = 0;
    while (idx < 6 && cyc < 200) begin
      @(posedge clk); #1;
      if (idx == 2 && !full_done) begin full_left = 4; full_done = 1; end
      hop_fifo_full0 = (full_left > 0);
      if (full_left > 0) full_left--;
      hop_in_valid = 1; hop_in_sop = (idx == 0); hop_in_eop = (idx == 5);
      hop_in_data = hops[idx]; hop_in_rci = 8'h21;
      @(negedge clk);
      if (started && !hop_in_ready) low++;
      if (hop_in_ready) begin idx++; started = 1; end
      cyc++;
    end
    @(posedge clk); #1;
    idle_inputs();
    check("bp_ready_low_cycles", 64'(low), 64'd4);
    check("bp_fifo0_contents", {63'd0, q_equal(fq0, hops)}, 64'd1);
    check("bp_meta_count", 64'(meta_q.size()), 64'd1);
    if (meta_q.size() > 0) check("bp_meta_rci", 64'(meta_q[0]), 64'h21);
    $display("backpressure packet: hops=%0d ready_low=%0d", idx, low);

    // Random packet stream with random gaps, back-pressure and parser release.
    do_reset();
    rand_phase = 1'b1;
    aborted = 0;
    for (int p = 0; p < 40 && !aborted; p++) begin
      b = p % 2;
      n = $urandom_range(1, 6);
      prci = RW'($urandom);
      hops.delete();
      for (int h = 0; h < n; h++) hops.push_back(DW'($urandom));
      for (int h = 0; h < n && !aborted; h++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          hop_in_valid = 0;
          hop_fifo_full0 = ($urandom_range(0, 3) == 0);
          hop_fifo_full1 = ($urandom_range(0, 3) == 0);
        end
        accepted = 0;
        waitc = 0;
        while (!accepted && waitc < 300) begin
          @(posedge clk); #1;
          hop_in_valid = 1; hop_in_sop = (h == 0); hop_in_eop = (h == n - 1);
          hop_in_data = hops[h]; hop_in_rci = prci;
          hop_fifo_full0 = ($urandom_range(0, 3) == 0);
          hop_fifo_full1 = ($urandom_range(0, 3) == 0);
          @(negedge clk);
          accepted = hop_in_ready;
          waitc++;
        end
        if (!accepted) begin
          check($sformatf("pkt%0d_beat%0d_accept_timeout", p, h), 64'd0, 64'd1);
          aborted = 1;
        end
      end
      @(posedge clk); #1;
      hop_in_valid = 0; hop_in_sop = 0; hop_in_eop = 0;
      if (aborted) break;
      got_q = (b == 0) ? fq0 : fq1;
      check($sformatf("pkt%0d_fifo%0d_contents", p, b), {63'd0, q_equal(got_q, hops)}, 64'd1);
      check($sformatf("pkt%0d_meta_count", p), 64'(meta_q.size()), 64'd1);
      if (meta_q.size() > 0) check($sformatf("pkt%0d_meta_rci", p), 64'(meta_q.pop_front()), 64'(prci));
      meta_q.delete();
      rel_cnt[b] = $urandom_range(1, 12);
      $display("pkt %0d buf=%0d hops=%0d rci=%0h", p, b, n, prci);
    end
    check("rand_proto_err_count", 64'(perr_cnt), 64'd0);
    rand_phase = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
